imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Producer end of the controller's instruction-memory interface.
- Accepts a host instruction stream over a valid/ready handshake and writes it into an internal instruction memory.
- Serves the decoder's read port with fixed 1-cycle latency.
- Sequences the decoder: one start pulse after the program is loaded, then waits for the decoder's done.

Parameters:
- IMEM_ADDR_W, 10, instruction memory address width; depth = 2^IMEM_ADDR_W words.
- INST_W, 32, instruction word width.
- OP_CODE_W, 4, opcode field width (word bits [INST_W-1 -: OP_CODE_W]).
- OP_BLOCK_END, 8, opcode value marking the end of an instruction block.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- load_start  in  1  pulse; begin loading a new program at address 0
- s_inst_data  in  INST_W  instruction word from host
- s_inst_valid  in  1  s_inst_data valid
- s_inst_ready  out  1  loader accepts a word this cycle
- imem_read_req  in  1  decoder read request
- imem_read_addr  in  IMEM_ADDR_W  decoder read address
- imem_read_data  out  INST_W  read data, 1 cycle after the request
- decoder_start  out  1  1-cycle start pulse to decoder
- decoder_done  in  1  decoder finished the program
- busy  out  1  high whenever state is not IDLE
- done  out  1  1-cycle pulse when a run completes or is aborted
- error  out  1  sticky; program overflowed memory without a terminator
- inst_count  out  IMEM_ADDR_W+1  words written in the current/last load

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - s_inst_ready, decoder_start, busy, done, error, inst_count = 0.
  - imem_read_data = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - load_start moves to LOAD.
  - Also clears the write address, inst_count and error.
- LOAD:
  - s_inst_ready = 1, combinational on state only; no dependence on s_inst_valid.
  - Each cycle with s_inst_valid && s_inst_ready:
    - mem[wr_addr] <= s_inst_data
    - wr_addr and inst_count increment.
  - Terminator word: opcode == OP_BLOCK_END and bit 0 == 1 (last-block flag). On accepting it (it is written), next state = START.
  - Overflow: the word written at address 2^IMEM_ADDR_W-1 is not a terminator.
    - Next state = DONE.
    - error <= 1.
    - Decoder is never started.
  - inst_count saturates at 2^IMEM_ADDR_W.
- START:
  - decoder_start = 1 for exactly one cycle.
  - Next state = RUN.
- RUN:
  - s_inst_ready = 0.
  - On decoder_done, next state = DONE.
  - decoder_done seen in any other state is ignored.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state = IDLE.
  - error remains asserted until the next load_start accepted in IDLE.
- load_start outside IDLE is ignored.
- Read port, independent of FSM state:
  - If imem_read_req, imem_read_data <= mem[imem_read_addr] on the next edge.
  - Otherwise imem_read_data holds its value.
  - Same-cycle read/write to the same address returns the old contents (read-before-write).
- Reset mid-operation:
  - Returns to IDLE and drops all outputs to reset values.
  - Partially loaded words remain in memory.
- Widths:
  - wr_addr is IMEM_ADDR_W bits.
  - inst_count is one bit wider so that a full memory reads as 2^IMEM_ADDR_W.

Test Plan:
1. Reset, then load_start; send 3 words: 0x1000_0004, 0x7000_0010, 0x8000_0001 with valid held high.
   - s_inst_ready is high for 3 cycles; inst_count = 3.
   - decoder_start pulses one cycle after the third handshake.
   - busy stays high until done.
2. From scenario 1, with FSM in RUN, assert decoder_done for one cycle.
   - done pulses the next cycle; busy falls; state is IDLE.
   - error = 0.
3. After load, issue reads at addresses 0, 1, 2 on consecutive cycles.
   - imem_read_data = 0x1000_0004, 0x7000_0010, 0x8000_0001, each one cycle after its request.
   - Data holds when imem_read_req = 0.
4. Host backpressure: toggle s_inst_valid 1,0,1,0,1 carrying words A, B, terminator 0x8000_0001.
   - Exactly 3 writes; inst_count = 3.
   - Idle cycles write nothing.
5. Overflow with IMEM_ADDR_W = 2: send 4 words with opcode 0x1.
   - After the 4th handshake, state goes to DONE; done pulses; error = 1.
   - decoder_start never asserts; inst_count = 4.
   - A subsequent load_start clears error.
6. Assert reset during LOAD after 2 words; then load_start with 1 terminator word 0x8000_0001.
   - inst_count restarts at 0 and ends at 1.
   - decoder_start pulses.
   - Address 1 still holds the earlier second word.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: producer side of the controller's instruction-memory interface.
// Accepts a host instruction stream (valid/ready) into an internal memory,
// serves the decoder read port with 1-cycle latency and sequences the decoder
// with a start pulse after a complete program has been loaded.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load_start        pulse in IDLE: begin loading a new program at address 0
//   s_inst_*          host instruction stream (valid/ready)
//   imem_read_*       decoder read port, data valid one cycle after request
//   decoder_start     1-cycle start pulse to the decoder
//   decoder_done      decoder finished the program
//   busy              high whenever the loader is not idle
//   done              1-cycle pulse when a run completes or is aborted
//   error             sticky overflow flag (memory filled without terminator)
//   inst_count        words written in the current/last load
module imem_loader #(
   parameter int unsigned IMEM_ADDR_W  = 10,
   parameter int unsigned INST_W       = 32,
   parameter int unsigned OP_CODE_W    = 4,
   parameter int unsigned OP_BLOCK_END = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_start,
   input  logic [INST_W-1:0]      s_inst_data,
   input  logic                   s_inst_valid,
   output logic                   s_inst_ready,
   input  logic                   imem_read_req,
   input  logic [IMEM_ADDR_W-1:0] imem_read_addr,
   output logic [INST_W-1:0]      imem_read_data,
   output logic                   decoder_start,
   input  logic                   decoder_done,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [IMEM_ADDR_W:0]   inst_count
);

   localparam int unsigned CNT_W = IMEM_ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << IMEM_ADDR_W;
   localparam logic [CNT_W-1:0]       CNT_MAX   = CNT_W'(DEPTH);
   localparam logic [IMEM_ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [OP_CODE_W-1:0]   OP_END    = OP_CODE_W'(OP_BLOCK_END);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IMEM_ADDR_W-1:0] wr_addr;
   logic [INST_W-1:0]      mem [DEPTH];

   logic accept_c;
   logic is_term_c;
   logic is_last_c;

   // Handshake qualifier and terminator / last-slot detection
   assign accept_c  = (state == ST_LOAD) && s_inst_valid;
   assign is_term_c = (s_inst_data[INST_W-1 -: OP_CODE_W] == OP_END) && s_inst_data[0];
   assign is_last_c = (wr_addr == ADDR_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (load_start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (accept_c) begin
               if (is_term_c)      state_nxt = ST_START;
               else if (is_last_c) state_nxt = ST_DONE;
            end
         end
         ST_START: state_nxt = ST_RUN;
         ST_RUN:   if (decoder_done) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      s_inst_ready  = 1'b0;
      decoder_start = 1'b0;
      done          = 1'b0;
      busy          = (state != ST_IDLE);
      case (state)
         ST_LOAD:  s_inst_ready  = 1'b1;
         ST_START: decoder_start = 1'b1;
         ST_DONE:  done          = 1'b1;
         default:  ;
      endcase
   end

   // Write pointer, word counter and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr    <= '0;
         inst_count <= '0;
         error      <= 1'b0;
      end else if ((state == ST_IDLE) && load_start) begin
         wr_addr    <= '0;
         inst_count <= '0;
         error      <= 1'b0;
      end else if (accept_c) begin
         wr_addr <= wr_addr + IMEM_ADDR_W'(1);
         if (inst_count != CNT_MAX) begin
            inst_count <= inst_count + CNT_W'(1);
         end
         if (is_last_c && !is_term_c) begin
            error <= 1'b1;
         end
      end
   end

   // Instruction memory write; contents survive reset
   always_ff @(posedge clk) begin
      if (accept_c) begin
         mem[wr_addr] <= s_inst_data;
      end
   end

   // Decoder read port; nonblocking read gives read-before-write on collision
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_read_data <= '0;
      end else if (imem_read_req) begin
         imem_read_data <= mem[imem_read_addr];
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: full-size instance for normal loads,
// reads, backpressure and mid-load reset; a 4-word instance for overflow.
module tb_imem_loader;

   localparam int unsigned AW  = 10;
   localparam int unsigned AW2 = 2;
   localparam int unsigned IW  = 32;

   localparam logic [IW-1:0] W0   = 32'h1000_0004;
   localparam logic [IW-1:0] W1   = 32'h7000_0010;
   localparam logic [IW-1:0] TERM = 32'h8000_0001;
   localparam logic [IW-1:0] WA   = 32'h2000_00A0;
   localparam logic [IW-1:0] WB   = 32'h3000_00B0;
   localparam logic [IW-1:0] JUNK = 32'hDEAD_BEEF;
   localparam logic [IW-1:0] WC   = 32'h2000_0011;
   localparam logic [IW-1:0] WD   = 32'h3000_0022;

   logic clk = 1'b0;
   logic reset;

   // Full-size instance
   logic          load_start, s_inst_valid, s_inst_ready;
   logic [IW-1:0] s_inst_data;
   logic          imem_read_req;
   logic [AW-1:0] imem_read_addr;
   logic [IW-1:0] imem_read_data;
   logic          decoder_start, decoder_done, busy, done, error;
   logic [AW:0]   inst_count;

   // Small instance
   logic           load_start2, s_inst_valid2, s_inst_ready2;
   logic [IW-1:0]  s_inst_data2;
   logic           imem_read_req2;
   logic [AW2-1:0] imem_read_addr2;
   logic [IW-1:0]  imem_read_data2;
   logic           decoder_start2, decoder_done2, busy2, done2, error2;
   logic [AW2:0]   inst_count2;

   int vectors = 0;
   int errors  = 0;
   int ds2_cnt = 0;

   always #5 clk = ~clk;

   imem_loader #(.IMEM_ADDR_W(AW), .INST_W(IW), .OP_CODE_W(4), .OP_BLOCK_END(8)) dut (
      .clk(clk), .reset(reset), .load_start(load_start),
      .s_inst_data(s_inst_data), .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready),
      .imem_read_req(imem_read_req), .imem_read_addr(imem_read_addr),
      .imem_read_data(imem_read_data), .decoder_start(decoder_start),
      .decoder_done(decoder_done), .busy(busy), .done(done), .error(error),
      .inst_count(inst_count)
   );

   imem_loader #(.IMEM_ADDR_W(AW2), .INST_W(IW), .OP_CODE_W(4), .OP_BLOCK_END(8)) dut2 (
      .clk(clk), .reset(reset), .load_start(load_start2),
      .s_inst_data(s_inst_data2), .s_inst_valid(s_inst_valid2), .s_inst_ready(s_inst_ready2),
      .imem_read_req(imem_read_req2), .imem_read_addr(imem_read_addr2),
      .imem_read_data(imem_read_data2), .decoder_start(decoder_start2),
      .decoder_done(decoder_done2), .busy(busy2), .done(done2), .error(error2),
      .inst_count(inst_count2)
   );

   always @(posedge clk) if (decoder_start2) ds2_cnt <= ds2_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_start = 0; s_inst_valid = 0; s_inst_data = '0; imem_read_req = 0;
      imem_read_addr = '0; decoder_done = 0;
      load_start2 = 0; s_inst_valid2 = 0; s_inst_data2 = '0; imem_read_req2 = 0;
      imem_read_addr2 = '0; decoder_done2 = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
      vectors++; if ({busy, s_inst_ready, decoder_start, done, error} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {busy, s_inst_ready, decoder_start, done, error}); end
      vectors++; if (inst_count !== 11'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", inst_count); end
      vectors++; if (imem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", imem_read_data); end
   endtask

   task automatic test_load_basic();
      logic [IW-1:0] words [3];
      int ready_cnt = 0;
      words[0] = W0; words[1] = W1; words[2] = TERM;
      load_start = 1; tick(); load_start = 0;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b exp=1", busy); end
      for (int i = 0; i < 3; i++) begin
         s_inst_data = words[i]; s_inst_valid = 1;
         if (s_inst_ready === 1'b1) ready_cnt++;
         tick();
      end
      s_inst_valid = 0;
      vectors++; if (ready_cnt != 3) begin errors++; $display("FAIL load_ready_cycles got=%0d exp=3", ready_cnt); end
      vectors++; if (decoder_start !== 1'b1 || s_inst_ready !== 1'b0) begin errors++; $display("FAIL load_start_pulse got=%b%b exp=10", decoder_start, s_inst_ready); end
      vectors++; if (inst_count !== 11'd3) begin errors++; $display("FAIL load_count got=%0d exp=3", inst_count); end
      tick();
      vectors++; if (decoder_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_state got=%b%b exp=01", decoder_start, busy); end
   endtask

   task automatic test_run_done();
      tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_hold got=%b%b exp=01", done, busy); end
      decoder_done = 1; tick(); decoder_done = 0;
      vectors++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b%b exp=11", done, busy); end
      tick();
      vectors++; if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL back_idle got=%b%b%b exp=000", done, busy, error); end
   endtask

   task automatic test_reads();
      logic [IW-1:0] exp [3];
      exp[0] = W0; exp[1] = W1; exp[2] = TERM;
      imem_read_req = 1;
      for (int i = 0; i < 3; i++) begin
         imem_read_addr = AW'(i);
         tick();
         vectors++; if (imem_read_data !== exp[i]) begin errors++; $display("FAIL read_addr%0d got=%h exp=%h", i, imem_read_data, exp[i]); end
      end
      imem_read_req = 0; imem_read_addr = '0;
      tick(); tick();
      vectors++; if (imem_read_data !== TERM) begin errors++; $display("FAIL read_hold got=%h exp=%h", imem_read_data, TERM); end
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] d [5];
      logic          v [5];
      d[0] = WA; d[1] = JUNK; d[2] = WB; d[3] = JUNK; d[4] = TERM;
      v[0] = 1;  v[1] = 0;    v[2] = 1;  v[3] = 0;    v[4] = 1;
      load_start = 1; tick(); load_start = 0;
      for (int i = 0; i < 5; i++) begin
         s_inst_data = d[i]; s_inst_valid = v[i];
         tick();
      end
      s_inst_valid = 0;
      vectors++; if (inst_count !== 11'd3 || decoder_start !== 1'b1) begin errors++; $display("FAIL bp_count got=%0d/%b exp=3/1", inst_count, decoder_start); end
      tick(); decoder_done = 1; tick(); decoder_done = 0; tick();
      imem_read_req = 1; imem_read_addr = 10'd1; tick();
      vectors++; if (imem_read_data !== WB) begin errors++; $display("FAIL bp_addr1 got=%h exp=%h", imem_read_data, WB); end
      imem_read_addr = 10'd2; tick();
      vectors++; if (imem_read_data !== TERM) begin errors++; $display("FAIL bp_addr2 got=%h exp=%h", imem_read_data, TERM); end
      imem_read_addr = 10'd3; tick();
      vectors++; if (imem_read_data === JUNK) begin errors++; $display("FAIL bp_addr3 got=%h exp=not %h", imem_read_data, JUNK); end
      imem_read_req = 0;
   endtask

   task automatic test_overflow();
      int ds_before = ds2_cnt;
      load_start2 = 1; tick(); load_start2 = 0;
      for (int i = 0; i < 4; i++) begin
         s_inst_data2 = 32'h1000_0000 + IW'(i); s_inst_valid2 = 1;
         vectors++; if (s_inst_ready2 !== 1'b1) begin errors++; $display("FAIL ovf_ready%0d got=%b exp=1", i, s_inst_ready2); end
         tick();
      end
      s_inst_valid2 = 0;
      vectors++; if (done2 !== 1'b1 || error2 !== 1'b1) begin errors++; $display("FAIL ovf_done_err got=%b%b exp=11", done2, error2); end
      vectors++; if (inst_count2 !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", inst_count2); end
      imem_read_req2 = 1; imem_read_addr2 = 2'd3;
      tick(); imem_read_req2 = 0;
      vectors++; if (busy2 !== 1'b0 || error2 !== 1'b1 || done2 !== 1'b0) begin errors++; $display("FAIL ovf_idle got=%b%b%b exp=010", busy2, error2, done2); end
      vectors++; if (imem_read_data2 !== 32'h1000_0003) begin errors++; $display("FAIL ovf_last_word got=%h exp=10000003", imem_read_data2); end
      vectors++; if (ds2_cnt != ds_before) begin errors++; $display("FAIL ovf_no_start got=%0d exp=%0d", ds2_cnt, ds_before); end
      load_start2 = 1; tick(); load_start2 = 0;
      vectors++; if (error2 !== 1'b0 || inst_count2 !== 3'd0) begin errors++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", error2, inst_count2); end
      s_inst_data2 = TERM; s_inst_valid2 = 1; tick(); s_inst_valid2 = 0;
      vectors++; if (decoder_start2 !== 1'b1) begin errors++; $display("FAIL ovf_reload_start got=%b exp=1", decoder_start2); end
      tick(); decoder_done2 = 1; tick(); decoder_done2 = 0; tick();
   endtask

   task automatic test_reset_mid_load();
      load_start = 1; tick(); load_start = 0;
      s_inst_valid = 1; s_inst_data = WC; tick();
      s_inst_data = WD; tick();
      s_inst_valid = 0; reset = 1; tick(); reset = 0;
      vectors++; if ({busy, s_inst_ready, decoder_start, done} !== 4'b0 || imem_read_data !== 32'h0) begin errors++; $display("FAIL midrst_flags got=%b/%h exp=0000/0", {busy, s_inst_ready, decoder_start, done}, imem_read_data); end
      vectors++; if (inst_count !== 11'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", inst_count); end
      load_start = 1; tick(); load_start = 0;
      s_inst_valid = 1; s_inst_data = TERM; tick(); s_inst_valid = 0;
      vectors++; if (decoder_start !== 1'b1 || inst_count !== 11'd1) begin errors++; $display("FAIL midrst_reload got=%b/%0d exp=1/1", decoder_start, inst_count); end
      tick(); decoder_done = 1; tick(); decoder_done = 0; tick();
      imem_read_req = 1; imem_read_addr = 10'd1; tick();
      vectors++; if (imem_read_data !== WD) begin errors++; $display("FAIL midrst_addr1 got=%h exp=%h", imem_read_data, WD); end
      imem_read_addr = 10'd0; tick();
      vectors++; if (imem_read_data !== TERM) begin errors++; $display("FAIL midrst_addr0 got=%h exp=%h", imem_read_data, TERM); end
      imem_read_req = 0;
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_run_done();
      test_reads();
      test_backpressure();
      test_overflow();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
